// File: rtl/mcsr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, bit positions, masks and op encoding.
package mcsr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHRDCTRL0 = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] INT_MSI_VAL = 5'd3;
    localparam logic [4:0] INT_MTI_VAL = 5'd7;
    localparam logic [4:0] INT_MEI_VAL = 5'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to machine mode, so it lives in the reset value and is never written
    localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK = (32'h1 << MSTATUS_MIE) | (32'h1 << MSTATUS_MPIE);

    // Only the three machine interrupt sources exist in mie/mip
    localparam logic [31:0] MIE_MASK = (32'h1 << INT_MSI_VAL) | (32'h1 << INT_MTI_VAL) | (32'h1 << INT_MEI_VAL);
    localparam logic [31:0] MIP_MASK = MIE_MASK;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    // Read-modify-write result of a CSR instruction before any per-register masking
    function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_val, logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = wdata;
            CSR_RS:  res = old_val | wdata;
            CSR_RC:  res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mcsr_file_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half writes (mcycle / minstret).
module mcsr_counter64 (
    input  logic        s_clk_i,
    input  logic        s_rst_i,
    input  logic        s_inc_i,
    input  logic        s_wr_lo_i,
    input  logic        s_wr_hi_i,
    input  logic [31:0] s_wdata_i,
    output logic [63:0] s_value_o
);

    // A write to either half wins over the increment and leaves the other half untouched
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            s_value_o <= '0;
        end else if (s_wr_lo_i) begin
            s_value_o[31:0] <= s_wdata_i;
        end else if (s_wr_hi_i) begin
            s_value_o[63:32] <= s_wdata_i;
        end else if (s_inc_i) begin
            s_value_o <= s_value_o + 64'd1;
        end
    end

endmodule

// File: rtl/mcsr_file.sv
// Machine-mode CSR responder: read/modify/write access, counters, trap/mret state and interrupt evaluation.
module mcsr_file
    import mcsr_pkg::*;
#(
    parameter logic [31:0] HARTID   = 32'h0,
    parameter logic [31:0] ISA_VAL  = 32'h4000_1104,
    parameter logic [31:0] TVEC_RST = 32'h0
) (
    input  logic        s_clk_i,
    input  logic        s_rst_i,
    input  logic        s_req_i,
    input  logic [11:0] s_add_i,
    input  logic [1:0]  s_op_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic        s_illegal_o,
    input  logic        s_instret_i,
    input  logic        s_trap_i,
    input  logic        s_trap_int_i,
    input  logic [4:0]  s_trap_cause_i,
    input  logic [31:0] s_trap_epc_i,
    input  logic [31:0] s_trap_tval_i,
    input  logic        s_mret_i,
    input  logic        s_msi_i,
    input  logic        s_mti_i,
    input  logic        s_mei_i,
    output logic        s_irq_o,
    output logic [4:0]  s_irq_cause_o,
    output logic [31:0] s_trap_target_o,
    output logic [31:0] s_mepc_o
);

    logic [31:0] mstatus_q, mtvec_q, mie_q, mscratch_q, mepc_q, mcause_q, mtval_q, mhrdctrl0_q, mip_q;
    logic [63:0] cycle_val, instret_val;
    logic [31:0] rd_data, wr_val, pending;
    logic        rd_known, illegal, csr_wr;
    csr_op_t     op;

    assign op = csr_op_t'(s_op_i);

    // Address decode: current value of the addressed CSR and whether the address exists
    always_comb begin
        rd_data  = 32'h0;
        rd_known = 1'b1;
        case (s_add_i)
            CSR_MSTATUS:   rd_data = mstatus_q;
            CSR_MISA:      rd_data = ISA_VAL;
            CSR_MIE:       rd_data = mie_q;
            CSR_MTVEC:     rd_data = mtvec_q;
            CSR_MSCRATCH:  rd_data = mscratch_q;
            CSR_MEPC:      rd_data = mepc_q;
            CSR_MCAUSE:    rd_data = mcause_q;
            CSR_MTVAL:     rd_data = mtval_q;
            CSR_MIP:       rd_data = mip_q;
            CSR_MHRDCTRL0: rd_data = mhrdctrl0_q;
            CSR_MCYCLE:    rd_data = cycle_val[31:0];
            CSR_MCYCLEH:   rd_data = cycle_val[63:32];
            CSR_MINSTRET:  rd_data = instret_val[31:0];
            CSR_MINSTRETH: rd_data = instret_val[63:32];
            CSR_MHARTID:   rd_data = HARTID;
            default:       rd_known = 1'b0;
        endcase
    end

    // Addresses with [11:10]==11 are read-only; any modifying op there is illegal
    assign illegal = !rd_known || ((op != CSR_READ) && (s_add_i[11:10] == 2'b11));
    assign wr_val  = csr_apply(op, rd_data, s_wdata_i);
    assign csr_wr  = s_req_i && !illegal && (op != CSR_READ) && !s_trap_i && !s_mret_i;

    mcsr_counter64 u_cycle (
        .s_clk_i   (s_clk_i),
        .s_rst_i   (s_rst_i),
        .s_inc_i   (1'b1),
        .s_wr_lo_i (csr_wr && (s_add_i == CSR_MCYCLE)),
        .s_wr_hi_i (csr_wr && (s_add_i == CSR_MCYCLEH)),
        .s_wdata_i (wr_val),
        .s_value_o (cycle_val)
    );

    mcsr_counter64 u_instret (
        .s_clk_i   (s_clk_i),
        .s_rst_i   (s_rst_i),
        .s_inc_i   (s_instret_i),
        .s_wr_lo_i (csr_wr && (s_add_i == CSR_MINSTRET)),
        .s_wr_hi_i (csr_wr && (s_add_i == CSR_MINSTRETH)),
        .s_wdata_i (wr_val),
        .s_value_o (instret_val)
    );

    // Response register: old value (or zero when illegal) returned the cycle after the request
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            s_rvalid_o  <= 1'b0;
            s_rdata_o   <= 32'h0;
            s_illegal_o <= 1'b0;
        end else begin
            s_rvalid_o  <= s_req_i;
            s_rdata_o   <= (s_req_i && !illegal) ? rd_data : 32'h0;
            s_illegal_o <= s_req_i && illegal;
        end
    end

    // CSR state: trap entry beats mret, which beats a software write in the same cycle
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            mstatus_q   <= MSTATUS_RST;
            mtvec_q     <= TVEC_RST & ~32'h2;
            mie_q       <= 32'h0;
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            mhrdctrl0_q <= 32'h0;
            mip_q       <= 32'h0;
        end else begin
            mip_q <= {20'b0, s_mei_i, 3'b0, s_mti_i, 3'b0, s_msi_i, 3'b0};
            if (s_trap_i) begin
                mepc_q                  <= {s_trap_epc_i[31:1], 1'b0};
                mcause_q                <= {s_trap_int_i, 26'b0, s_trap_cause_i};
                mtval_q                 <= s_trap_tval_i;
                mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
                mstatus_q[MSTATUS_MIE]  <= 1'b0;
            end else if (s_mret_i) begin
                mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
                mstatus_q[MSTATUS_MPIE] <= 1'b1;
            end else if (csr_wr) begin
                case (s_add_i)
                    CSR_MSTATUS:   mstatus_q   <= (MSTATUS_RST & ~MSTATUS_WMASK) | (wr_val & MSTATUS_WMASK);
                    CSR_MIE:       mie_q       <= wr_val & MIE_MASK;
                    CSR_MTVEC:     mtvec_q     <= wr_val & ~32'h2;
                    CSR_MSCRATCH:  mscratch_q  <= wr_val;
                    CSR_MEPC:      mepc_q      <= {wr_val[31:1], 1'b0};
                    CSR_MCAUSE:    mcause_q    <= wr_val;
                    CSR_MTVAL:     mtval_q     <= wr_val;
                    CSR_MHRDCTRL0: mhrdctrl0_q <= wr_val;
                    default: ;
                endcase
            end
        end
    end

    assign pending = mie_q & mip_q & MIP_MASK;
    assign s_irq_o = mstatus_q[MSTATUS_MIE] && (pending != 32'h0);
    assign s_mepc_o = mepc_q;

    // Highest-priority enabled pending interrupt: external, then software, then timer
    always_comb begin
        s_irq_cause_o = 5'd0;
        if (pending[INT_MEI_VAL]) begin
            s_irq_cause_o = INT_MEI_VAL;
        end else if (pending[INT_MSI_VAL]) begin
            s_irq_cause_o = INT_MSI_VAL;
        end else if (pending[INT_MTI_VAL]) begin
            s_irq_cause_o = INT_MTI_VAL;
        end
    end

    // Handler address; vectored mode offsets interrupts by 4*cause
    always_comb begin
        s_trap_target_o = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && s_trap_int_i) begin
            s_trap_target_o = {mtvec_q[31:2], 2'b00} + {25'b0, s_trap_cause_i, 2'b00};
        end
    end

endmodule

// File: tb/tb_mcsr_file.sv
// Self-checking bench for mcsr_file: directed sequence followed by random traffic against a behavioural model.
module tb_mcsr_file;

    logic        s_clk_i = 1'b0;
    logic        s_rst_i, s_req_i, s_instret_i, s_trap_i, s_trap_int_i, s_mret_i;
    logic        s_msi_i, s_mti_i, s_mei_i;
    logic [11:0] s_add_i;
    logic [1:0]  s_op_i;
    logic [31:0] s_wdata_i, s_trap_epc_i, s_trap_tval_i;
    logic [4:0]  s_trap_cause_i;
    logic        s_rvalid_o, s_illegal_o, s_irq_o;
    logic [31:0] s_rdata_o, s_trap_target_o, s_mepc_o;
    logic [4:0]  s_irq_cause_o;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural model of the architectural CSR state
    logic        m_st_mie, m_st_mpie;
    logic [31:0] m_mtvec, m_mie_reg, m_mscratch, m_mepc, m_mcause, m_mtval, m_hrd, m_mip;
    logic [63:0] m_cycle, m_instret;
    logic        exp_rvalid, exp_illegal;
    logic [31:0] exp_rdata;

    logic [11:0] addr_pool [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'h7C0, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                    12'hF14, 12'h7FF, 12'hC00};

    mcsr_file dut (
        .s_clk_i(s_clk_i), .s_rst_i(s_rst_i), .s_req_i(s_req_i), .s_add_i(s_add_i), .s_op_i(s_op_i),
        .s_wdata_i(s_wdata_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o), .s_illegal_o(s_illegal_o),
        .s_instret_i(s_instret_i), .s_trap_i(s_trap_i), .s_trap_int_i(s_trap_int_i),
        .s_trap_cause_i(s_trap_cause_i), .s_trap_epc_i(s_trap_epc_i), .s_trap_tval_i(s_trap_tval_i),
        .s_mret_i(s_mret_i), .s_msi_i(s_msi_i), .s_mti_i(s_mti_i), .s_mei_i(s_mei_i), .s_irq_o(s_irq_o),
        .s_irq_cause_o(s_irq_cause_o), .s_trap_target_o(s_trap_target_o), .s_mepc_o(s_mepc_o)
    );

    always #5 s_clk_i = ~s_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void model_read(input logic [11:0] a, output logic known, output logic [31:0] v);
        known = 1'b1;
        v     = 32'h0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_st_mpie) << 7) | (32'(m_st_mie) << 3);
            12'h301: v = 32'h4000_1104;
            12'h304: v = m_mie_reg;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
            12'h7C0: v = m_hrd;
            12'hB00: v = m_cycle[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB02: v = m_instret[31:0];
            12'hB82: v = m_instret[63:32];
            12'hF14: v = 32'h0;
            default: known = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] model_irq_cause();
        logic [31:0] p;
        p = m_mie_reg & m_mip;
        if (p[11]) return 5'd11;
        if (p[3])  return 5'd3;
        if (p[7])  return 5'd7;
        return 5'd0;
    endfunction

    // Advance the model by one clock edge using the inputs presented in that cycle
    task automatic model_edge();
        logic        known, ill, wr;
        logic [31:0] old_v, new_v;
        logic [63:0] cyc_n, ins_n;
        if (s_rst_i) begin
            m_st_mie = 0; m_st_mpie = 0; m_mtvec = 0; m_mie_reg = 0; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_hrd = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
            exp_rvalid = 0; exp_rdata = 0; exp_illegal = 0;
        end else begin
            model_read(s_add_i, known, old_v);
            ill         = !known || (s_op_i != 2'b00 && s_add_i[11:10] == 2'b11);
            exp_rvalid  = s_req_i;
            exp_illegal = s_req_i && ill;
            exp_rdata   = (s_req_i && !ill) ? old_v : 32'h0;
            wr          = s_req_i && !ill && s_op_i != 2'b00 && !s_trap_i && !s_mret_i;
            case (s_op_i)
                2'b01:   new_v = s_wdata_i;
                2'b10:   new_v = old_v | s_wdata_i;
                default: new_v = old_v & ~s_wdata_i;
            endcase
            cyc_n = m_cycle + 64'd1;
            ins_n = s_instret_i ? m_instret + 64'd1 : m_instret;
            if (s_trap_i) begin
                m_mepc    = s_trap_epc_i & ~32'h1;
                m_mcause  = (s_trap_int_i ? 32'h8000_0000 : 32'h0) + 32'(s_trap_cause_i);
                m_mtval   = s_trap_tval_i;
                m_st_mpie = m_st_mie;
                m_st_mie  = 0;
            end else if (s_mret_i) begin
                m_st_mie  = m_st_mpie;
                m_st_mpie = 1;
            end else if (wr) begin
                case (s_add_i)
                    12'h300: begin m_st_mie = new_v[3]; m_st_mpie = new_v[7]; end
                    12'h304: m_mie_reg  = new_v & 32'h888;
                    12'h305: m_mtvec    = new_v & ~32'h2;
                    12'h340: m_mscratch = new_v;
                    12'h341: m_mepc     = new_v & ~32'h1;
                    12'h342: m_mcause   = new_v;
                    12'h343: m_mtval    = new_v;
                    12'h7C0: m_hrd      = new_v;
                    12'hB00: cyc_n = {m_cycle[63:32], new_v};
                    12'hB80: cyc_n = {new_v, m_cycle[31:0]};
                    12'hB02: ins_n = {m_instret[63:32], new_v};
                    12'hB82: ins_n = {new_v, m_instret[31:0]};
                    default: ;
                endcase
            end
            m_cycle   = cyc_n;
            m_instret = ins_n;
            m_mip     = (s_mei_i ? 32'h800 : 32'h0) | (s_mti_i ? 32'h80 : 32'h0) | (s_msi_i ? 32'h8 : 32'h0);
        end
    endtask

    // One cycle: drive request, check combinational outputs, clock, check the registered response
    task automatic applyStimulus(input logic req, input logic [11:0] add, input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] tgt;
        s_req_i = req; s_add_i = add; s_op_i = op; s_wdata_i = wd;
        #1;
        if (!s_rst_i) begin
            checkOutput("irq", 32'(s_irq_o), 32'(m_st_mie && ((m_mie_reg & m_mip) != 0)));
            checkOutput("irq_cause", 32'(s_irq_cause_o), 32'(model_irq_cause()));
            checkOutput("mepc_out", s_mepc_o, m_mepc);
            if (s_trap_i) begin
                tgt = m_mtvec & ~32'h3;
                if (m_mtvec[0] && s_trap_int_i) tgt = tgt + 4 * 32'(s_trap_cause_i);
                checkOutput("trap_target", s_trap_target_o, tgt);
            end
        end
        @(posedge s_clk_i);
        model_edge();
        #1;
        checkOutput("rvalid", 32'(s_rvalid_o), 32'(exp_rvalid));
        if (exp_rvalid || s_rst_i) begin
            checkOutput("rdata", s_rdata_o, exp_rdata);
            checkOutput("illegal", 32'(s_illegal_o), 32'(exp_illegal));
        end
        @(negedge s_clk_i);
        s_req_i = 0; s_trap_i = 0; s_mret_i = 0;
    endtask

    initial begin
        s_rst_i = 1; s_req_i = 0; s_add_i = 0; s_op_i = 0; s_wdata_i = 0; s_instret_i = 0;
        s_trap_i = 0; s_trap_int_i = 0; s_trap_cause_i = 0; s_trap_epc_i = 0; s_trap_tval_i = 0;
        s_mret_i = 0; s_msi_i = 0; s_mti_i = 0; s_mei_i = 0;
        @(negedge s_clk_i);

        // Reset with a request pending: no response
        applyStimulus(1, 12'h300, 2'b00, 0);
        applyStimulus(1, 12'h300, 2'b00, 0);
        checkOutput("rst_rvalid", 32'(s_rvalid_o), 32'h0);
        s_rst_i = 0;

        // Identity reads after reset
        applyStimulus(1, 12'h300, 2'b00, 0);
        checkOutput("mstatus_rst", s_rdata_o, 32'h1800);
        applyStimulus(1, 12'h301, 2'b00, 0);
        checkOutput("misa", s_rdata_o, 32'h4000_1104);
        applyStimulus(1, 12'hF14, 2'b00, 0);
        checkOutput("mhartid", s_rdata_o, 32'h0);
        checkOutput("mhartid_legal", 32'(s_illegal_o), 32'h0);

        // mscratch RW/RS/RC chain
        applyStimulus(1, 12'h340, 2'b01, 32'hA5A5_0000);
        applyStimulus(1, 12'h340, 2'b10, 32'h0000_00FF);
        applyStimulus(1, 12'h340, 2'b11, 32'hA000_000F);
        applyStimulus(1, 12'h340, 2'b00, 0);
        checkOutput("mscratch_final", s_rdata_o, 32'h05A5_00F0);

        // minstret carry into the high half, read-only and unknown addresses
        s_instret_i = 1;
        applyStimulus(1, 12'hB02, 2'b01, 32'hFFFF_FFFF);
        applyStimulus(1, 12'hF14, 2'b01, 32'h1234_5678);
        checkOutput("mhartid_wr_illegal", 32'(s_illegal_o), 32'h1);
        checkOutput("mhartid_wr_rdata", s_rdata_o, 32'h0);
        applyStimulus(1, 12'hB02, 2'b00, 0);
        checkOutput("minstret_wrap", s_rdata_o, 32'h0);
        applyStimulus(1, 12'hB82, 2'b00, 0);
        checkOutput("minstreth_carry", s_rdata_o, 32'h1);
        applyStimulus(1, 12'h7FF, 2'b00, 0);
        checkOutput("unknown_illegal", 32'(s_illegal_o), 32'h1);
        checkOutput("unknown_rdata", s_rdata_o, 32'h0);
        applyStimulus(1, 12'hF14, 2'b00, 0);
        checkOutput("mhartid_kept", s_rdata_o, 32'h0);
        s_instret_i = 0;

        // mcycle 64-bit wrap
        applyStimulus(1, 12'hB80, 2'b01, 32'hFFFF_FFFF);
        applyStimulus(1, 12'hB00, 2'b01, 32'hFFFF_FFFF);
        applyStimulus(1, 12'hB00, 2'b00, 0);
        applyStimulus(1, 12'hB00, 2'b00, 0);
        checkOutput("mcycle_wrap", s_rdata_o, 32'h0);
        applyStimulus(1, 12'hB80, 2'b00, 0);
        checkOutput("mcycleh_wrap", s_rdata_o, 32'h0);

        // Interrupt enable and vectored trap entry
        applyStimulus(1, 12'h305, 2'b01, 32'h8000_0003);
        applyStimulus(1, 12'h300, 2'b01, 32'h0000_0008);
        applyStimulus(1, 12'h304, 2'b01, 32'h0000_0800);
        s_mei_i = 1; s_mti_i = 1;
        applyStimulus(0, 12'h0, 2'b00, 0);
        checkOutput("irq_on", 32'(s_irq_o), 32'h1);
        checkOutput("irq_cause_mei", 32'(s_irq_cause_o), 32'd11);
        s_trap_i = 1; s_trap_int_i = 1; s_trap_cause_i = 5'd11; s_trap_epc_i = 32'h0000_0404; s_trap_tval_i = 32'h0;
        #1;
        checkOutput("trap_target_vec", s_trap_target_o, 32'h8000_002C);
        applyStimulus(0, 12'h0, 2'b00, 0);
        applyStimulus(1, 12'h342, 2'b00, 0);
        checkOutput("mcause_int", s_rdata_o, 32'h8000_000B);
        applyStimulus(1, 12'h300, 2'b00, 0);
        checkOutput("mstatus_trap", s_rdata_o, 32'h0000_1880);

        // Trap beats a same-cycle mepc write, then mret restores MIE
        s_mei_i = 0; s_mti_i = 0;
        applyStimulus(1, 12'h300, 2'b01, 32'h0000_0008);
        s_trap_i = 1; s_trap_int_i = 0; s_trap_cause_i = 5'd2; s_trap_epc_i = 32'h100; s_trap_tval_i = 32'hDEAD_BEEF;
        applyStimulus(1, 12'h341, 2'b01, 32'h1234);
        applyStimulus(1, 12'h341, 2'b00, 0);
        checkOutput("mepc_trap_wins", s_rdata_o, 32'h100);
        s_mret_i = 1;
        applyStimulus(0, 12'h0, 2'b00, 0);
        applyStimulus(1, 12'h300, 2'b00, 0);
        checkOutput("mstatus_mret", s_rdata_o, 32'h0000_1888);
        checkOutput("mepc_out_mret", s_mepc_o, 32'h100);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s_instret_i    = 1'($urandom);
            s_msi_i        = 1'($urandom);
            s_mti_i        = 1'($urandom);
            s_mei_i        = 1'($urandom);
            s_trap_i       = ($urandom_range(0, 15) == 0);
            s_mret_i       = ($urandom_range(0, 15) == 0);
            s_trap_int_i   = 1'($urandom);
            s_trap_cause_i = 5'($urandom);
            s_trap_epc_i   = $urandom;
            s_trap_tval_i  = $urandom;
            applyStimulus(1'($urandom), addr_pool[$urandom_range(0, 16)], 2'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
